// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V lb..sw requests into word-aligned memory_bus accesses.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses instead of faulting them.
module load_store_unit #(
    parameter int ADDRESS_WIDTH    = 16,
    parameter int READ_WAIT_CYCLES = 1
) (
    input  logic                     raw_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              store_data,
    output logic [31:0]              load_data,
    output logic                     done,
    output logic                     fault,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] bus_address,
    output logic [31:0]              bus_data_out,
    input  logic [31:0]              bus_data_in,
    output logic [3:0]               bus_write_mask,
    output logic                     bus_enable,
    output logic                     bus_write_enable
);
    localparam int CW = (READ_WAIT_CYCLES > 1) ? $clog2(READ_WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(READ_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic                     is_store_q, is_store_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [31:0]              load_data_q, load_data_d;
    logic                     fault_q, fault_d;

    logic       idle, req_store, sz_b, sz_h, sz_w, valid, aligned, bad;
    logic [2:0] req_f3;
    logic [1:0] off;
    logic [3:0] bm, wm_lo;
    logic [31:0] repl, ld_sh, ld_ext;
    logic       unused_hi;

    // Decode looks at the live inputs in IDLE and at the latched request afterwards.
    assign idle      = (state_q == S_IDLE);
    assign req_store = idle ? is_store : is_store_q;
    assign req_f3    = idle ? funct3 : funct3_q;
    assign off       = idle ? addr[1:0] : addr_q[1:0];
    assign unused_hi = ^addr[31:ADDRESS_WIDTH];

    assign sz_b    = (req_f3[1:0] == 2'b00);
    assign sz_h    = (req_f3[1:0] == 2'b01);
    assign sz_w    = (req_f3[1:0] == 2'b10);
    assign valid   = req_store ? (req_f3[2] == 1'b0 && req_f3[1:0] != 2'b11)
                               : (req_f3[1:0] != 2'b11 && !(req_f3[2] && req_f3[1]));
    assign aligned = !(sz_h && off[0]) && !(sz_w && off != 2'b00);
    assign bm      = sz_w ? 4'b1111 : (sz_h ? 4'b0011 : 4'b0001);
    assign wm_lo   = bm << off;
    assign repl    = sz_b ? {4{wdata_q[7:0]}} : (sz_h ? {2{wdata_q[15:0]}} : wdata_q);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        second_q, second_d;
    logic [31:0] lo_q, lo_d;
    logic        cross;
    logic [7:0]  m8;
    logic [63:0] st_win;

    assign bad    = !valid;
    assign cross  = (sz_h && off == 2'b11) || (sz_w && off != 2'b00);
    assign m8     = {4'b0000, bm} << off;
    assign st_win = {32'b0, wdata_q} << {off, 3'b000};
    assign ld_sh  = 32'({(second_q ? bus_data_in : 32'b0),
                         (second_q ? lo_q : bus_data_in)} >> {off, 3'b000});

    assign bus_address    = {addr_q[ADDRESS_WIDTH-1:2], 2'b00}
                          + (second_q ? ADDRESS_WIDTH'(4) : ADDRESS_WIDTH'(0));
    assign bus_data_out   = second_q ? st_win[63:32] : (aligned ? repl : st_win[31:0]);
    assign bus_write_mask = (state_q == S_WRITE) ? (second_q ? m8[7:4] : wm_lo) : 4'b0000;
`else
    assign bad            = !valid || !aligned;
    assign ld_sh          = bus_data_in >> {off, 3'b000};
    assign bus_address    = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
    assign bus_data_out   = repl;
    assign bus_write_mask = (state_q == S_WRITE) ? wm_lo : 4'b0000;
`endif

    always_comb begin
        ld_ext = ld_sh;
        unique case (1'b1)
            sz_b:    ld_ext = {{24{~req_f3[2] & ld_sh[7]}}, ld_sh[7:0]};
            sz_h:    ld_ext = {{16{~req_f3[2] & ld_sh[15]}}, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        second_d    = second_q;
        lo_d        = lo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr[ADDRESS_WIDTH-1:0];
                    wdata_d    = store_data;
                    fault_d    = bad;
                    cnt_d      = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    second_d   = 1'b0;
`endif
                    if (bad)           state_d = S_DONE;
                    else if (is_store) state_d = S_WRITE;
                    else               state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == LAST) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (cross && !second_q) begin
                        lo_d     = bus_data_in;
                        second_d = 1'b1;
                        state_d  = S_REQ;
                    end else begin
`else
                    begin
`endif
                        load_data_d = ld_ext;
                        state_d     = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WRITE: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (cross && !second_q) second_d = 1'b1;
                else                    state_d  = S_DONE;
`else
                state_d = S_DONE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            second_q    <= 1'b0;
            lo_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            second_q    <= second_d;
            lo_q        <= lo_d;
`endif
        end
    end

    assign load_data        = load_data_q;
    assign done             = (state_q == S_DONE);
    assign fault            = done && fault_q;
    assign busy             = !idle;
    assign bus_enable       = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_WRITE);
    assign bus_write_enable = (state_q == S_WRITE);
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory on the bus.
module tb_load_store_unit;
    logic        raw_clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] load_data;
    logic        done, fault, busy;
    logic [15:0] bus_address;
    logic [31:0] bus_data_out, bus_data_in;
    logic [3:0]  bus_write_mask;
    logic        bus_enable, bus_write_enable;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mem [0:15];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_data = 32'h0;

    load_store_unit #(.ADDRESS_WIDTH(16), .READ_WAIT_CYCLES(1)) dut (
        .raw_clk(raw_clk), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .load_data(load_data), .done(done), .fault(fault), .busy(busy),
        .bus_address(bus_address), .bus_data_out(bus_data_out),
        .bus_data_in(bus_data_in), .bus_write_mask(bus_write_mask),
        .bus_enable(bus_enable), .bus_write_enable(bus_write_enable)
    );

    always #5 raw_clk = ~raw_clk;

    assign bus_data_in = mem[bus_address[5:2]];

    always @(posedge raw_clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (bus_enable && bus_write_enable) begin
            for (int i = 0; i < 4; i++)
                if (bus_write_mask[i])
                    mem[bus_address[5:2]][8*i +: 8] <= bus_data_out[8*i +: 8];
        end
    end

    task automatic tick();
        @(posedge raw_clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] d);
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        tick();
        start = 1'b0;
    endtask

    // Called one cycle after issue; returns the cycle number at which done was seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [63:0] got;
        reset = 1'b1;
        tick(); tick();
        got = {load_data, done, fault, busy, bus_enable, bus_write_enable,
               bus_write_mask, bus_address};
        total_cnt++;
        if (got !== 64'h0)
            $display("FAIL reset_outputs got=%h exp=0", got);
        else pass_cnt++;
        total_cnt++;
        if (bus_data_out !== 32'h0)
            $display("FAIL reset_wdata got=%h exp=0", bus_data_out);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("FAIL reset_release got=%b exp=00", {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_store();
        for (int i = 0; i < 16; i++) preload(4'(i), 32'h0);
        issue(1'b1, 3'b010, 32'h0000_0004, 32'hDEAD_BEEF);
        total_cnt++;
        if ({bus_address, bus_write_mask, bus_write_enable, bus_enable, done}
            !== {16'h0004, 4'b1111, 1'b1, 1'b1, 1'b0})
            $display("FAIL sw_cycle1 got=%h/%b/%b%b%b exp=0004/1111/110",
                     bus_address, bus_write_mask, bus_write_enable, bus_enable, done);
        else pass_cnt++;
        total_cnt++;
        if (bus_data_out !== 32'hDEAD_BEEF)
            $display("FAIL sw_data got=%h exp=deadbeef", bus_data_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({done, fault, bus_enable, bus_write_mask} !== {1'b1, 1'b0, 1'b0, 4'b0000})
            $display("FAIL sw_cycle2 got=%b%b%b/%b exp=100/0000",
                     done, fault, bus_enable, bus_write_mask);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (mem[1] !== 32'hDEAD_BEEF)
            $display("FAIL sw_mem got=%h exp=deadbeef", mem[1]);
        else pass_cnt++;

        issue(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5);
        total_cnt++;
        if ({bus_address, bus_write_mask, bus_data_out} !== {16'h0010, 4'b1000, 32'hA5A5_A5A5})
            $display("FAIL sb_cycle1 got=%h/%b/%h exp=0010/1000/a5a5a5a5",
                     bus_address, bus_write_mask, bus_data_out);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (mem[4] !== 32'hA500_0000)
            $display("FAIL sb_mem got=%h exp=a5000000", mem[4]);
        else pass_cnt++;

        issue(1'b1, 3'b001, 32'h0000_0016, 32'h1234_ABCD);
        total_cnt++;
        if ({bus_address, bus_write_mask, bus_data_out} !== {16'h0014, 4'b1100, 32'hABCD_ABCD})
            $display("FAIL sh_cycle1 got=%h/%b/%h exp=0014/1100/abcdabcd",
                     bus_address, bus_write_mask, bus_data_out);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (mem[5] !== 32'hABCD_0000)
            $display("FAIL sh_mem got=%h exp=abcd0000", mem[5]);
        else pass_cnt++;
    endtask

    task automatic test_load();
        logic [2:0]  f3s  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100};
        logic [31:0] adrs [7] = '{32'h20, 32'h21, 32'h22, 32'h22, 32'h20, 32'h21, 32'h23};
        logic [31:0] exps [7] = '{32'hFFFF_FFFF, 32'h0000_00F0, 32'hFFFF_8001,
                                  32'h0000_8001, 32'h8001_F0FF, 32'hFFFF_FFF0,
                                  32'h0000_0080};
        int cyc;
        preload(4'd8, 32'h8001_F0FF);
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, f3s[i], adrs[i], 32'h0);
            total_cnt++;
            if ({bus_address, bus_enable, bus_write_enable, bus_write_mask}
                !== {16'h0020, 1'b1, 1'b0, 4'b0000})
                $display("FAIL load%0d_req got=%h/%b%b/%b exp=0020/10/0000", i,
                         bus_address, bus_enable, bus_write_enable, bus_write_mask);
            else pass_cnt++;
            wait_done(cyc);
            total_cnt++;
            if (cyc != 3 || load_data !== exps[i] || fault !== 1'b0)
                $display("FAIL load%0d got=%h cyc=%0d fault=%b exp=%h cyc=3 fault=0",
                         i, load_data, cyc, fault, exps[i]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({done, busy, load_data} !== {1'b0, 1'b0, 32'h0000_0080})
            $display("FAIL load_hold got=%b%b/%h exp=00/00000080", done, busy, load_data);
        else pass_cnt++;
    endtask

    task automatic test_fault();
        int cyc;
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
        wait_done(cyc);
        tick();
`ifndef LSU_MISALIGN_SPLIT_EN
        issue(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        total_cnt++;
        if ({done, fault, bus_enable, busy} !== 4'b1101 || load_data !== 32'h8001_F0FF)
            $display("FAIL lw_misalign got=%b%b%b%b/%h exp=1101/8001f0ff",
                     done, fault, bus_enable, busy, load_data);
        else pass_cnt++;
        tick();
        issue(1'b1, 3'b001, 32'h0000_0011, 32'hFFFF_FFFF);
        total_cnt++;
        if ({done, fault, bus_write_enable, bus_write_mask} !== {1'b1, 1'b1, 1'b0, 4'b0000})
            $display("FAIL sh_misalign got=%b%b%b/%b exp=110/0000",
                     done, fault, bus_write_enable, bus_write_mask);
        else pass_cnt++;
        tick();
`endif
        issue(1'b0, 3'b011, 32'h0000_0020, 32'h0);
        total_cnt++;
        if ({done, fault, bus_enable} !== 3'b110 || load_data !== 32'h8001_F0FF)
            $display("FAIL load_bad_f3 got=%b%b%b/%h exp=110/8001f0ff",
                     done, fault, bus_enable, load_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({done, fault} !== 2'b00)
            $display("FAIL fault_pulse got=%b%b exp=00", done, fault);
        else pass_cnt++;
        issue(1'b1, 3'b100, 32'h0000_0020, 32'h0);
        total_cnt++;
        if ({done, fault, bus_enable} !== 3'b110)
            $display("FAIL store_bad_f3 got=%b%b%b exp=110", done, fault, bus_enable);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        preload(4'd2, 32'h0);
        preload(4'd3, 32'h0);
        issue(1'b1, 3'b010, 32'h0000_0008, 32'h1111_1111);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010;
        addr = 32'h0000_000C; store_data = 32'h2222_2222;
        tick();
        total_cnt++;
        if ({done, fault, busy} !== 3'b101)
            $display("FAIL b2b_done got=%b%b%b exp=101", done, fault, busy);
        else pass_cnt++;
        start = 1'b0;
        tick();
        total_cnt++;
        if (mem[2] !== 32'h1111_1111 || mem[3] !== 32'h0 || busy !== 1'b0)
            $display("FAIL b2b_ignore got=%h/%h/%b exp=11111111/00000000/0",
                     mem[2], mem[3], busy);
        else pass_cnt++;
        issue(1'b0, 3'b010, 32'h0000_0008, 32'h0);
        wait_done(cyc);
        total_cnt++;
        if (cyc != 3 || load_data !== 32'h1111_1111)
            $display("FAIL b2b_load got=%h cyc=%0d exp=11111111 cyc=3", load_data, cyc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
        tick();
        total_cnt++;
        if ({bus_enable, busy, done} !== 3'b110)
            $display("FAIL mid_wait got=%b%b%b exp=110", bus_enable, busy, done);
        else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        total_cnt++;
        if ({bus_enable, busy, done, load_data} !== {3'b000, 32'h0})
            $display("FAIL mid_async got=%b%b%b/%h exp=000/00000000",
                     bus_enable, busy, done, load_data);
        else pass_cnt++;
        seen = 0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        total_cnt++;
        if (seen != 0)
            $display("FAIL mid_no_done got=%0d exp=0", seen);
        else pass_cnt++;
        issue(1'b0, 3'b100, 32'h0000_0021, 32'h0);
        wait_done(cyc);
        total_cnt++;
        if (cyc != 3 || load_data !== 32'h0000_00F0)
            $display("FAIL mid_recover got=%h cyc=%0d exp=000000f0 cyc=3", load_data, cyc);
        else pass_cnt++;
        tick();
    endtask

`ifdef LSU_MISALIGN_SPLIT_EN
    task automatic test_split();
        preload(4'd0, 32'h4433_2211);
        preload(4'd1, 32'h8877_6655);
        issue(1'b0, 3'b010, 32'h0000_0002, 32'h0);
        total_cnt++;
        if ({bus_enable, bus_address} !== {1'b1, 16'h0000})
            $display("FAIL split_rd1 got=%b/%h exp=1/0000", bus_enable, bus_address);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if ({bus_enable, bus_address} !== {1'b1, 16'h0004})
            $display("FAIL split_rd2 got=%b/%h exp=1/0004", bus_enable, bus_address);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (done !== 1'b1 || load_data !== 32'h6655_4433)
            $display("FAIL split_load got=%b/%h exp=1/66554433", done, load_data);
        else pass_cnt++;
        tick();
        issue(1'b1, 3'b010, 32'h0000_0006, 32'hAABB_CCDD);
        total_cnt++;
        if ({bus_address, bus_write_mask, bus_data_out[31:16]} !== {16'h0004, 4'b1100, 16'hCCDD})
            $display("FAIL split_wr1 got=%h/%b/%h exp=0004/1100/ccdd",
                     bus_address, bus_write_mask, bus_data_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus_address, bus_write_mask, bus_data_out[15:0]} !== {16'h0008, 4'b0011, 16'hAABB})
            $display("FAIL split_wr2 got=%h/%b/%h exp=0008/0011/aabb",
                     bus_address, bus_write_mask, bus_data_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b1 || mem[1] !== 32'hCCDD_6655)
            $display("FAIL split_store got=%b/%h exp=1/ccdd6655", done, mem[1]);
        else pass_cnt++;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store();
        test_load();
        test_fault();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_MISALIGN_SPLIT_EN
        test_split();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Bus initiator between the CPU execute stage and memory_bus.
- Turns one RISC-V load/store request (lb/lh/lw/lbu/lhu/sb/sh/sw) into word-aligned bus transactions: byte-lane write masks, store-data lane placement, read-latency wait states, load-data extraction with sign/zero extension.
- Reports alignment and encoding faults.

Parameters:
- ADDRESS_WIDTH, 16: bus_address width; addresses wrap modulo 2^ADDRESS_WIDTH.
- READ_WAIT_CYCLES, 1: cycles, minimum 1, between presenting a read address and sampling bus_data_in.

Ports:
- raw_clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request strobe; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RISC-V funct3 (width/sign).
- addr  input  32  effective byte address.
- store_data  input  32  store source (rs2).
- load_data  output  32  extended load result.
- done  output  1  one-cycle completion pulse.
- fault  output  1  valid with done; request rejected.
- busy  output  1  high in every state except IDLE.
- bus_address  output  ADDRESS_WIDTH  word-aligned address; low 2 bits always 0.
- bus_data_out  output  32  write data to memory_bus data_in.
- bus_data_in  input  32  read data from memory_bus data_out.
- bus_write_mask  output  4  bit i enables byte lane i (bits 8i+7:8i), active-high, little-endian.
- bus_enable  output  1  transaction active.
- bus_write_enable  output  1  write strobe.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports raw_clk, reset).
- Reset, including mid-operation: state goes to IDLE immediately. All outputs 0. Any in-flight access is abandoned and no done pulse is issued.
- Request latching: in IDLE, start=1 latches is_store, funct3, addr, store_data. Inputs are ignored while busy.
- States: IDLE, REQ, WAIT, WRITE, DONE.
- Valid loads: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- Valid stores: funct3 000 sb, 001 sh, 010 sw. All other codes fault.
- Misalignment (split disabled): lh/lhu with addr[0]=1, or lw/sw with addr[1:0]!=0, faults. sh with addr[0]=1 faults.
- Fault path: IDLE -> DONE. No bus activity. done=1, fault=1 in cycle 1; load_data unchanged.
- Load path: IDLE -> REQ (cycle 1) -> WAIT (READ_WAIT_CYCLES cycles) -> DONE.
  - bus_enable=1 and bus_address held through REQ and WAIT; bus_write_enable=0, bus_write_mask=0.
  - bus_data_in is captured on the edge ending the last WAIT cycle.
  - done/load_data valid in cycle 2+READ_WAIT_CYCLES.
- Load extraction: lane selected by addr[1:0] (byte) or addr[1] (half). lb/lh sign-extend; lbu/lhu zero-extend. load_data holds its value until the next completed load.
- Store path: IDLE -> WRITE (cycle 1) -> DONE (cycle 2).
  - In WRITE: bus_enable=1, bus_write_enable=1 for exactly one cycle.
  - Write masks: sb = 1<<addr[1:0]; sh = 0011 or 1100; sw = 1111.
  - bus_data_out = store_data replicated to every lane: byte x4, half x2.
- DONE: done=1 one cycle, then IDLE. start is accepted again from the cycle after DONE.
- Idle bus: bus_enable, bus_write_enable and bus_write_mask are 0 in IDLE and DONE.
- bus_address = addr[ADDRESS_WIDTH-1:2], 2'b00.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Without it: misaligned accesses fault as above.
- With it, no alignment faults:
  - Accesses contained in one word (e.g. lh at offset 1) use one bus access with shifted lanes and mask.
  - Word-crossing accesses use two sequential accesses, first to A = addr & ~3, then to A+4 (wraps at 2^ADDRESS_WIDTH).
  - Crossing loads: REQ/WAIT twice, then merge bytes; done in cycle 3+2*READ_WAIT_CYCLES.
  - Crossing stores: WRITE to A with upper-lane mask, then WRITE to A+4 with lower-lane mask; done in cycle 3.
  - Reset between the two halves leaves the first write committed.

Test Plan:
- sw addr=0x0004 data=0xDEADBEEF -> cycle1 bus_address=0x0004, mask=1111, we=1; cycle2 done=1, fault=0.
- sb addr=0x0013 data=0x000000A5 -> bus_address=0x0010, mask=1000, bus_data_out=0xA5A5A5A5.
- Memory word 0x8001F0FF at 0x0020; lb 0x0020 -> 0xFFFFFFFF; lbu 0x0021 -> 0x000000F0; lh 0x0022 -> 0xFFFF8001; done in cycle 3 with READ_WAIT_CYCLES=1.
- lw addr=0x0006, split disabled -> done=1, fault=1 in cycle 1, bus_enable never asserted.
- Split enabled, word 0x44332211 at 0x0000 and 0x88776655 at 0x0004; lw 0x0002 -> 0x66554433, two reads at 0x0000 then 0x0004.
- Reset asserted during WAIT -> bus_enable drops without a clock edge, no done; next start completes normally.
